// File: rtl/fifo_rd_stream_if.sv
// ============================================================================
// Module      : fifo_rd_stream_if
// Description : Bundles the FIFO pop port and the downstream valid/ready stream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             i_fifo_empty;
  logic             o_fifo_rd_en;
  logic [WIDTH-1:0] i_fifo_rd_data;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [1:0]       o_level;

  // master = the read-stream consumer, slave = FIFO + downstream environment
  modport master (
    input  i_fifo_empty, i_fifo_rd_data, i_ready,
    output o_fifo_rd_en, o_valid, o_data, o_level
  );

  modport slave (
    output i_fifo_empty, i_fifo_rd_data, i_ready,
    input  o_fifo_rd_en, o_valid, o_data, o_level
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module      : fifo_rd_stream
// Description : Drains an async FIFO read port into a 3-entry skid buffer and
//               presents the words as an in-order valid/ready stream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fifo_rd_stream_if.master    bus
);

  localparam logic [1:0] c_LAST = 2'd2;

  logic [WIDTH-1:0] r_mem [0:2];
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_inflight;

  logic [2:0]       w_occupancy;
  logic             w_pop;
  logic             w_depart;

  function automatic logic [1:0] f_next(input logic [1:0] ptr);
    return (ptr == c_LAST) ? 2'd0 : ptr + 2'd1;
  endfunction

  // The in-flight word already owns a slot, so it counts towards occupancy;
  // the pop decision never looks at i_ready.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_pop       = ~rst & ~bus.i_fifo_empty & (w_occupancy <= 3'd2);
  assign w_depart    = (r_count != 2'd0) & bus.i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= bus.i_fifo_rd_data;
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (w_depart) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_depart};
    end
  end

  assign bus.o_fifo_rd_en = w_pop;
  assign bus.o_valid      = (r_count != 2'd0);
  assign bus.o_data       = r_mem[r_rd_ptr];
  assign bus.o_level      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Directed and randomised bench for fifo_rd_stream with a
//               queue-based reference model of the popped-word stream
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.WIDTH(W)) bus ();
  fifo_rd_stream #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // FIFO source model: words src_mem[src_rd .. src_wr-1] are still in the FIFO
  logic [W-1:0] src_mem [0:2047];
  int           src_wr = 0;
  int           src_rd = 0;
  logic         gate_empty = 1'b1;
  assign bus.i_fifo_empty = gate_empty | (src_rd == src_wr);

  // exp_q holds every popped, not yet delivered word (in flight or buffered)
  logic [W-1:0] exp_q [$];
  logic         pend = 1'b0;
  int           cyc = 0;
  int           rden_cnt = 0;
  int           rden_cyc_q [$];
  logic [W-1:0] dlv_q [$];
  int           dlv_cyc_q [$];
  int           tot = 0;
  int           bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
      pend                <= 1'b0;
      src_rd              <= src_wr;
      bus.i_fifo_rd_data  <= '0;
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        dlv_q.push_back(bus.o_data);
        dlv_cyc_q.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.o_fifo_rd_en) begin
        exp_q.push_back(src_mem[src_rd]);
        bus.i_fifo_rd_data <= src_mem[src_rd];
        src_rd             <= src_rd + 1;
        rden_cnt           <= rden_cnt + 1;
        rden_cyc_q.push_back(cyc);
      end
      pend <= bus.o_fifo_rd_en;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    src_mem[src_wr] = v;
    src_wr          = src_wr + 1;
  endtask

  // One clock cycle: check every output at the falling edge, then advance
  task automatic step();
    int sz;
    int lvl;
    @(negedge clk);
    if (rst) begin
      chk("rst_valid", {31'b0, bus.o_valid}, 0);
      chk("rst_level", {30'b0, bus.o_level}, 0);
      chk("rst_rd_en", {31'b0, bus.o_fifo_rd_en}, 0);
      chk("rst_data",  {24'b0, bus.o_data}, 0);
    end else begin
      sz  = exp_q.size();
      lvl = sz - (pend ? 1 : 0);
      chk("rd_en", {31'b0, bus.o_fifo_rd_en}, (!bus.i_fifo_empty && sz <= 2) ? 1 : 0);
      chk("level", {30'b0, bus.o_level}, lvl);
      chk("valid", {31'b0, bus.o_valid}, (lvl != 0) ? 1 : 0);
      if (lvl > 0) chk("data", {24'b0, bus.o_data}, {24'b0, exp_q[0]});
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int b_rd;
    int b_dl;
    int b_src;
    rst         = 1'b1;
    bus.i_ready = 1'b0;
    @(posedge clk);
    #2;
    repeat (3) step();
    rst = 1'b0;

    // Idle with an empty FIFO
    b_rd = rden_cnt;
    repeat (10) step();
    chk("idle_rd_en_pulses", rden_cnt - b_rd, 0);
    chk("idle_data", {24'b0, bus.o_data}, 0);

    // Five words at full throughput
    for (int i = 1; i <= 5; i++) push(8'(8'h11 * i));
    bus.i_ready = 1'b1;
    b_rd = rden_cnt;
    b_dl = dlv_q.size();
    gate_empty = 1'b0;
    for (int n = 0; n < 60 && dlv_q.size() < b_dl + 5; n++) step();
    repeat (3) step();
    chk("t2_delivered", dlv_q.size() - b_dl, 5);
    chk("t2_rd_en_pulses", rden_cnt - b_rd, 5);
    if (dlv_q.size() >= b_dl + 5 && rden_cnt > b_rd) begin
      chk("t2_latency", dlv_cyc_q[b_dl] - rden_cyc_q[b_rd], 2);
      for (int i = 0; i < 5; i++) chk("t2_word", {24'b0, dlv_q[b_dl + i]}, 32'h11 * (i + 1));
      for (int i = 1; i < 5; i++) chk("t2_gap", dlv_cyc_q[b_dl + i] - dlv_cyc_q[b_dl + i - 1], 1);
    end

    // Eight words under full backpressure, then drain
    gate_empty  = 1'b1;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    b_rd = rden_cnt;
    b_dl = dlv_q.size();
    gate_empty = 1'b0;
    repeat (10) step();
    chk("t3_rd_en_pulses", rden_cnt - b_rd, 3);
    chk("t3_level", {30'b0, bus.o_level}, 3);
    chk("t3_valid", {31'b0, bus.o_valid}, 1);
    chk("t3_data", {24'b0, bus.o_data}, 32'hA0);
    bus.i_ready = 1'b1;
    for (int n = 0; n < 60 && dlv_q.size() < b_dl + 8; n++) step();
    repeat (3) step();
    chk("t3_delivered", dlv_q.size() - b_dl, 8);
    chk("t3_total_pulses", rden_cnt - b_rd, 8);
    if (dlv_q.size() >= b_dl + 8) begin
      for (int i = 0; i < 8; i++) chk("t3_word", {24'b0, dlv_q[b_dl + i]}, 32'hA0 + i);
    end

    // 1000 random words with random stalls on both sides
    b_src = src_wr;
    b_dl  = dlv_q.size();
    for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
    for (int n = 0; n < 20000 && dlv_q.size() < b_dl + 1000; n++) begin
      gate_empty  = ($urandom_range(0, 3) == 0);
      bus.i_ready = 1'($urandom_range(0, 1));
      step();
    end
    gate_empty  = 1'b1;
    bus.i_ready = 1'b1;
    repeat (4) step();
    chk("t4_delivered", dlv_q.size() - b_dl, 1000);
    if (dlv_q.size() >= b_dl + 1000) begin
      for (int i = 0; i < 1000; i++) chk("t4_word", {24'b0, dlv_q[b_dl + i]}, {24'b0, src_mem[b_src + i]});
    end

    // Reset while two words are buffered and one is in flight
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(8'h60 + i));
    gate_empty = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.o_level == 2'd2 && pend) break;
      step();
    end
    chk("t5_pre_level", {30'b0, bus.o_level}, 2);
    chk("t5_pre_inflight", {31'b0, pend}, 1);
    b_dl = dlv_q.size();
    rst  = 1'b1;
    step();
    chk("t5_rst_valid", {31'b0, bus.o_valid}, 0);
    chk("t5_rst_level", {30'b0, bus.o_level}, 0);
    rst         = 1'b0;
    gate_empty  = 1'b1;
    bus.i_ready = 1'b1;
    step();
    push(8'h99);
    b_rd = rden_cnt;
    gate_empty = 1'b0;
    for (int n = 0; n < 20 && dlv_q.size() < b_dl + 1; n++) step();
    repeat (4) step();
    chk("t5_delivered", dlv_q.size() - b_dl, 1);
    if (dlv_q.size() > b_dl && rden_cnt > b_rd) begin
      chk("t5_word", {24'b0, dlv_q[b_dl]}, 32'h99);
      chk("t5_latency", dlv_cyc_q[b_dl] - rden_cyc_q[b_rd], 2);
    end

    // Seven words with i_ready toggling every cycle
    gate_empty  = 1'b1;
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 7; i++) push(8'(i));
    b_dl = dlv_q.size();
    gate_empty = 1'b0;
    for (int n = 0; n < 80 && dlv_q.size() < b_dl + 7; n++) begin
      bus.i_ready = ~bus.i_ready;
      step();
    end
    repeat (3) step();
    chk("t6_delivered", dlv_q.size() - b_dl, 7);
    if (dlv_q.size() >= b_dl + 7) begin
      for (int i = 0; i < 7; i++) chk("t6_word", {24'b0, dlv_q[b_dl + i]}, i + 1);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

`default_nettype wire
